branch_resolve_unit: RTL

- Pipelined, parametrised branch resolution unit for the rv32i core. It supersedes the single-cycle combinational branch comparator.
- Takes `rs1`, `rs2`, `funct3`, `pc`, `imm` and the fetch-stage prediction. Produces taken/not-taken, resolved next-PC, misprediction and misalignment flags.
- Two-stage pipeline with valid/ready handshakes on both sides and a flush input. Sits between the execute-stage operand mux and the PC-redirect logic.

---
 rtl/rv32i_pkg.sv | 17 +
 rtl/branch_resolve_unit_if.sv | 41 ++++
 rtl/branch_cmp.sv | 36 +++
 rtl/branch_resolve_unit.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/rv32i_pkg.sv
// Shared rv32i definitions used by the branch resolution path.
//   DEF_XLEN  : default operand / PC width
//   funct3_e  : conditional-branch funct3 encodings
package rv32i_pkg;

  localparam int unsigned DEF_XLEN = 32;

  typedef enum logic [2:0] {
    F3_BEQ  = 3'b000,
    F3_BNE  = 3'b001,
    F3_BLT  = 3'b100,
    F3_BGE  = 3'b101,
    F3_BLTU = 3'b110,
    F3_BGEU = 3'b111
  } funct3_e;

endpackage

// File: rtl/branch_resolve_unit_if.sv
// Request/response bundle of branch_resolve_unit.
//   master : requester side (drives in_* request fields and out_ready)
//   slave  : the unit (drives in_ready and the out_* result fields)
interface branch_resolve_unit_if #(
  parameter int unsigned XLEN = rv32i_pkg::DEF_XLEN
) ();

  logic            in_valid;
  logic            in_ready;
  logic            in_branch;
  logic [2:0]      in_funct3;
  logic [XLEN-1:0] in_rs1;
  logic [XLEN-1:0] in_rs2;
  logic [XLEN-1:0] in_pc;
  logic [XLEN-1:0] in_imm;
  logic            in_pred_taken;
  logic [XLEN-1:0] in_pred_target;

  logic            out_valid;
  logic            out_ready;
  logic            out_taken;
  logic [XLEN-1:0] out_next_pc;
  logic            out_mispredict;
  logic            out_misaligned;
  logic            out_illegal;

  modport master (
    output in_valid, in_branch, in_funct3, in_rs1, in_rs2, in_pc, in_imm,
           in_pred_taken, in_pred_target, out_ready,
    input  in_ready, out_valid, out_taken, out_next_pc, out_mispredict,
           out_misaligned, out_illegal
  );

  modport slave (
    input  in_valid, in_branch, in_funct3, in_rs1, in_rs2, in_pc, in_imm,
           in_pred_taken, in_pred_target, out_ready,
    output in_ready, out_valid, out_taken, out_next_pc, out_mispredict,
           out_misaligned, out_illegal
  );

endinterface

// File: rtl/branch_cmp.sv
// Combinational RV32I branch comparator.
//   branch  : 1 = conditional branch, 0 = non-branch (never taken)
//   funct3  : branch condition encoding
//   rs1/rs2 : operands
//   taken   : condition holds
//   illegal : branch with reserved funct3 (010/011)
module branch_cmp
  import rv32i_pkg::*;
#(
  parameter int unsigned XLEN = DEF_XLEN
) (
  input  logic            branch,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            taken,
  output logic            illegal
);

  always_comb begin
    taken   = 1'b0;
    illegal = 1'b0;
    if (branch) begin
      case (funct3)
        F3_BEQ:  taken = (rs1 == rs2);
        F3_BNE:  taken = (rs1 != rs2);
        F3_BLT:  taken = ($signed(rs1) <  $signed(rs2));
        F3_BGE:  taken = ($signed(rs1) >= $signed(rs2));
        F3_BLTU: taken = (rs1 <  rs2);
        F3_BGEU: taken = (rs1 >= rs2);
        default: illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Two-stage pipelined branch resolution unit.
//   clk, rst (sync, active high), flush (kills all in-flight entries)
//   bus : branch_resolve_unit_if.slave -- request handshake in, result handshake out
//   Optional macro BRU_STATS_EN adds stat_branches / stat_mispredicts
//   saturating counters of delivered branches and mispredictions.
// S1 registers the compare result plus pc/imm/prediction; S2 registers the
// resolved next PC and flags.
module branch_resolve_unit
  import rv32i_pkg::*;
#(
  parameter int unsigned XLEN       = DEF_XLEN,
  parameter int unsigned ILEN_BYTES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  branch_resolve_unit_if.slave bus
`ifdef BRU_STATS_EN
  ,
  output logic [31:0] stat_branches,
  output logic [31:0] stat_mispredicts
`endif
);

  localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(ILEN_BYTES - 1);

  logic            w_s1_adv, w_s2_adv, w_accept, w_s2_load;
  logic            w_cmp_taken, w_cmp_illegal;
  logic [XLEN-1:0] w_next_pc;
  logic            w_mispredict, w_misaligned;

  // Held low for the first cycle after reset so in_ready rises one cycle later.
  logic            r_rdy_en;
  logic            r_s1_valid, r_s2_valid;

  logic [XLEN-1:0] r_s1_pc, r_s1_imm, r_s1_pred_target;
  logic            r_s1_pred_taken, r_s1_taken, r_s1_illegal;

  logic            r_taken, r_mispredict, r_misaligned, r_illegal;
  logic [XLEN-1:0] r_next_pc;

  assign w_s2_adv     = !r_s2_valid | bus.out_ready;
  assign w_s1_adv     = !r_s1_valid | w_s2_adv;
  assign bus.in_ready = w_s1_adv & !flush & r_rdy_en;
  assign w_accept     = bus.in_valid & bus.in_ready;
  assign w_s2_load    = r_s1_valid & w_s2_adv & !flush;

  branch_cmp #(.XLEN(XLEN)) u_cmp (
    .branch  (bus.in_branch),
    .funct3  (bus.in_funct3),
    .rs1     (bus.in_rs1),
    .rs2     (bus.in_rs2),
    .taken   (w_cmp_taken),
    .illegal (w_cmp_illegal)
  );

  always_comb begin
    w_next_pc    = r_s1_taken ? (r_s1_pc + r_s1_imm) : (r_s1_pc + XLEN'(ILEN_BYTES));
    w_mispredict = (r_s1_taken != r_s1_pred_taken) | (w_next_pc != r_s1_pred_target);
    w_misaligned = r_s1_taken & ((w_next_pc & ALIGN_MASK) != '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdy_en   <= 1'b0;
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
    end else begin
      r_rdy_en <= 1'b1;
      if (flush) begin
        r_s1_valid <= 1'b0;
        r_s2_valid <= 1'b0;
      end else begin
        if (w_s1_adv) r_s1_valid <= w_accept;
        if (w_s2_adv) r_s2_valid <= r_s1_valid;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_pc          <= '0;
      r_s1_imm         <= '0;
      r_s1_pred_target <= '0;
      r_s1_pred_taken  <= 1'b0;
      r_s1_taken       <= 1'b0;
      r_s1_illegal     <= 1'b0;
    end else if (w_accept) begin
      r_s1_pc          <= bus.in_pc;
      r_s1_imm         <= bus.in_imm;
      r_s1_pred_target <= bus.in_pred_target;
      r_s1_pred_taken  <= bus.in_pred_taken;
      r_s1_taken       <= w_cmp_taken;
      r_s1_illegal     <= w_cmp_illegal;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_taken      <= 1'b0;
      r_next_pc    <= '0;
      r_mispredict <= 1'b0;
      r_misaligned <= 1'b0;
      r_illegal    <= 1'b0;
    end else if (w_s2_load) begin
      r_taken      <= r_s1_taken;
      r_next_pc    <= w_next_pc;
      r_mispredict <= w_mispredict;
      r_misaligned <= w_misaligned;
      r_illegal    <= r_s1_illegal;
    end
  end

  assign bus.out_valid      = r_s2_valid;
  assign bus.out_taken      = r_taken;
  assign bus.out_next_pc    = r_next_pc;
  assign bus.out_mispredict = r_mispredict;
  assign bus.out_misaligned = r_misaligned;
  assign bus.out_illegal    = r_illegal;

`ifdef BRU_STATS_EN
  logic        r_s1_branch, r_s2_branch;
  logic [31:0] r_stat_br, r_stat_mp;
  logic        w_out_hs;

  // A handshake coinciding with flush is void, so it is not counted.
  assign w_out_hs = r_s2_valid & bus.out_ready & !flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_branch <= 1'b0;
      r_s2_branch <= 1'b0;
    end else begin
      if (w_accept)  r_s1_branch <= bus.in_branch;
      if (w_s2_load) r_s2_branch <= r_s1_branch;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stat_br <= '0;
      r_stat_mp <= '0;
    end else if (w_out_hs) begin
      if (r_s2_branch && (r_stat_br != '1))  r_stat_br <= r_stat_br + 32'd1;
      if (r_mispredict && (r_stat_mp != '1)) r_stat_mp <= r_stat_mp + 32'd1;
    end
  end

  assign stat_branches    = r_stat_br;
  assign stat_mispredicts = r_stat_mp;
`endif

endmodule
